mem_access_unit: RTL

Memory-stage load/store unit that sits directly upstream of the data memory. It translates MEM-stage byte-addressed requests into word-indexed memory port activity and performs byte and halfword stores as a two-cycle read-modify-write. It sign- or zero-extends load data and registers the result as the MEM/WB latch. It also flags misaligned accesses.

---
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with sub-word read-modify-write stores.
// Revision 1.0
`default_nettype none

module mem_access_unit (
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] mem_ra,
  input  logic [31:0] mem_do,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_di,
  output logic        mem_wr,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic [31:0] fault_addr
);

  typedef enum logic [0:0] {IDLE = 1'b0, RMW = 1'b1} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nxt;
  logic [7:0]  hold_idx;
  logic [31:0] hold_word;

  logic [31:0] index;
  logic        bad_req;
  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        do_load, do_fault, do_sub;

  assign index = {24'b0, req_addr[9:2]};

  always_comb begin
    bad_req = (req_size == 2'b11) ||
              (req_size == SZ_HALF && req_addr[0]) ||
              (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

  // Word accesses are aligned by the time they reach the datapath, so the half shift is 0.
  always_comb begin
    shamt     = (req_size == SZ_BYTE) ? {req_addr[1:0], 3'b000} : {req_addr[1], 4'b0000};
    lane_mask = (req_size == SZ_BYTE) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    merged    = (mem_do & ~lane_mask) | ((req_wdata << shamt) & lane_mask);
    lane      = mem_do >> shamt;
    case (req_size)
      SZ_BYTE: load_val = {{24{~req_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: load_val = {{16{~req_unsigned & lane[15]}}, lane[15:0]};
      default: load_val = mem_do;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_ra    = 32'b0;
    mem_wa    = 32'b0;
    mem_di    = 32'b0;
    mem_wr    = 1'b0;
    do_load   = 1'b0;
    do_fault  = 1'b0;
    do_sub    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            do_fault = 1'b1;
          end else if (!req_we) begin
            mem_ra  = index;
            do_load = 1'b1;
          end else if (req_size == SZ_WORD) begin
            mem_wa = index;
            mem_di = req_wdata;
            mem_wr = 1'b1;
          end else begin
            mem_ra    = index;
            stall     = 1'b1;
            do_sub    = 1'b1;
            state_nxt = RMW;
          end
        end
      end
      RMW: begin
        // The held store is still on req_*; it retires here without being re-decoded.
        mem_wa    = {24'b0, hold_idx};
        mem_di    = hold_word;
        mem_wr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!Resetn) begin
      mem_wr = 1'b0;
      mem_wa = 32'b0;
      mem_di = 32'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      hold_idx   <= 8'b0;
      hold_word  <= 32'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'b0;
      wb_data    <= 32'b0;
      misalign   <= 1'b0;
      fault_addr <= 32'b0;
    end else begin
      state    <= state_nxt;
      wb_valid <= do_load;
      misalign <= do_fault;
      if (do_load) begin
        wb_rd   <= req_rd;
        wb_data <= load_val;
      end
      if (do_fault) fault_addr <= req_addr;
      if (do_sub) begin
        hold_idx  <= req_addr[9:2];
        hold_word <= merged;
      end
    end
  end

endmodule

`default_nettype wire
